// File: rtl/prm_chk_pkg.sv
// Shared types and constants for the PRM edge-check sequencer.
package prm_chk_pkg;

   localparam int CODE_W    = 15;
   localparam int RES_W_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      EVAL,
      EMIT,
      DONE
   } state_e;

endpackage

// File: rtl/prm_edge_res_packer.sv
// Packs per-edge mask bits into result words and presents them on a valid/ready port.
module prm_edge_res_packer
   import prm_chk_pkg::*;
#(
   parameter int RES_W = RES_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic             bit_i,
   input  logic             last_i,
   output logic             full_o,
   input  logic             res_ready_i,
   output logic             res_valid_o,
   output logic [RES_W-1:0] res_word_o,
   output logic             res_last_o
);

   localparam int BW = $clog2(RES_W);

   logic [BW-1:0]    bidx_q, bidx_d;
   logic [RES_W-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             flush;

   // full_o depends only on state so the sequencer can pick EMIT without a comb loop
   assign full_o = (bidx_q == BW'(RES_W - 1));
   assign flush  = wr_i && (full_o || last_i);

   always_comb begin
      bidx_d  = bidx_q;
      word_d  = word_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (clr_i) begin
         bidx_d  = '0;
         word_d  = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else begin
         if (valid_q && res_ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            word_d  = '0;
         end
         if (wr_i) begin
            word_d[bidx_q] = bit_i;
            bidx_d         = flush ? '0 : bidx_q + BW'(1);
            if (flush) begin
               valid_d = 1'b1;
               last_d  = last_i;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bidx_q  <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         bidx_q  <= bidx_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign res_valid_o = valid_q;
   assign res_word_o  = word_q;
   assign res_last_o  = last_q;

endmodule

// File: rtl/prm_edge_chk_sched.sv
// Sweeps a list of roadmap edges through the shared PRM edge checker and packs the masks.
// Define PRM_CHK_PIPE_EN to register chk_mask_i (two-cycle EVAL).
module prm_edge_chk_sched
   import prm_chk_pkg::*;
#(
   parameter int AW    = 10,
   parameter int CW    = 11,
   parameter int RES_W = RES_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [AW-1:0]     edge_base_i,
   input  logic [CW-1:0]     edge_cnt_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [CW-1:0]     blocked_o,
   output logic              mem_req_o,
   output logic [AW-1:0]     mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [CODE_W-1:0] mem_rdata_i,
   output logic [CODE_W-1:0] chk_code_o,
   input  logic              chk_mask_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [RES_W-1:0]  res_word_o,
   output logic              res_last_o
);

   state_e            state_q, state_d;
   logic [AW-1:0]     base_q, base_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     blocked_q, blocked_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              pk_clr, pk_wr, pk_full, mask_bit, eval_fire, last_edge;
`ifdef PRM_CHK_PIPE_EN
   logic              ph_q, ph_d;
   logic              mask_q, mask_d;
`endif

   assign last_edge = (idx_q == cnt_q - CW'(1));

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      blocked_d = blocked_q;
      code_d    = code_q;
      pk_clr    = 1'b0;
      pk_wr     = 1'b0;
      eval_fire = 1'b0;
`ifdef PRM_CHK_PIPE_EN
      ph_d      = ph_q;
      mask_d    = mask_q;
      mask_bit  = mask_q;
`else
      mask_bit  = chk_mask_i;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               base_d    = edge_base_i;
               cnt_d     = edge_cnt_i;
               idx_d     = '0;
               blocked_d = '0;
               pk_clr    = 1'b1;
               state_d   = (edge_cnt_i == '0) ? DONE : FETCH;
            end
         end
         FETCH: if (mem_gnt_i) state_d = WAIT;
         WAIT: begin
            if (mem_rvalid_i) begin
               code_d  = mem_rdata_i;
               state_d = EVAL;
            end
         end
         EVAL: begin
`ifdef PRM_CHK_PIPE_EN
            // first cycle drives the code and captures the mask, second cycle consumes it
            if (!ph_q) begin
               ph_d   = 1'b1;
               mask_d = chk_mask_i;
            end else begin
               ph_d      = 1'b0;
               eval_fire = 1'b1;
            end
`else
            eval_fire = 1'b1;
`endif
            if (eval_fire) begin
               pk_wr = 1'b1;
               if (mask_bit && (blocked_q != '1)) blocked_d = blocked_q + CW'(1);
               idx_d   = idx_q + CW'(1);
               state_d = (pk_full || last_edge) ? EMIT : FETCH;
            end
         end
         EMIT: begin
            if (res_valid_o && res_ready_i) state_d = res_last_o ? DONE : FETCH;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         blocked_q <= '0;
         code_q    <= '0;
`ifdef PRM_CHK_PIPE_EN
         ph_q      <= 1'b0;
         mask_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         blocked_q <= blocked_d;
         code_q    <= code_d;
`ifdef PRM_CHK_PIPE_EN
         ph_q      <= ph_d;
         mask_q    <= mask_d;
`endif
      end
   end

   prm_edge_res_packer #(.RES_W(RES_W)) u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (pk_clr),
      .wr_i        (pk_wr),
      .bit_i       (mask_bit),
      .last_i      (last_edge),
      .full_o      (pk_full),
      .res_ready_i (res_ready_i),
      .res_valid_o (res_valid_o),
      .res_word_o  (res_word_o),
      .res_last_o  (res_last_o)
   );

   assign busy_o     = (state_q == FETCH) || (state_q == WAIT) ||
                       (state_q == EVAL)  || (state_q == EMIT);
   assign done_o     = (state_q == DONE);
   assign mem_req_o  = (state_q == FETCH);
   assign mem_addr_o = base_q + idx_q[AW-1:0];
   assign chk_code_o = code_q;
   assign blocked_o  = blocked_q;

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Directed bench for prm_edge_chk_sched: memory responder, checker model and result sink.
module tb_prm_edge_chk_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_i;
   logic [9:0]  edge_base_i;
   logic [10:0] edge_cnt_i;
   logic        busy_o, done_o;
   logic [10:0] blocked_o;
   logic        mem_req_o;
   logic [9:0]  mem_addr_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [14:0] mem_rdata_i;
   logic [14:0] chk_code_o;
   logic        chk_mask_i;
   logic        res_valid_o, res_ready_i;
   logic [31:0] res_word_o;
   logic        res_last_o;

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus configuration, written only by the main sequence
   int           gnt_delay = 0;
   int           rd_lat    = 1;
   int           stall_len = 0;
   bit           spur_en   = 1'b0;
   logic [1023:0] mask_mem = '0;

   // observations, written only by the responder / sink processes
   logic [9:0]  got_addr[$];
   logic [31:0] got_words[$];
   logic        got_last[$];

   always #5 clk = ~clk;

   prm_edge_chk_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .edge_base_i  (edge_base_i),
      .edge_cnt_i   (edge_cnt_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .blocked_o    (blocked_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .chk_code_o   (chk_code_o),
      .chk_mask_i   (chk_mask_i),
      .res_valid_o  (res_valid_o),
      .res_ready_i  (res_ready_i),
      .res_word_o   (res_word_o),
      .res_last_o   (res_last_o)
   );

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Edge RAM returns {5'h14, addr}; the checker model only recognises that tag.
   initial begin
      bit         rv_pend = 1'b0;
      int         rv_dly  = 0;
      logic [9:0] rv_addr = '0;
      bit         req_seen = 1'b0;
      int         req_age  = 0;
      logic [9:0] held_addr = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      chk_mask_i   = 1'b0;
      forever begin
         @(negedge clk);
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         chk_mask_i   = (chk_code_o[14:10] == 5'h14) ? mask_mem[chk_code_o[9:0]] : 1'b0;
         if (!rst_n) begin
            rv_pend  = 1'b0;
            req_seen = 1'b0;
         end else if (rv_pend) begin
            if (rv_dly <= 1) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = {5'h14, rv_addr};
               rv_pend      = 1'b0;
            end else begin
               rv_dly--;
            end
         end else if (mem_req_o) begin
            if (!req_seen) begin
               req_seen  = 1'b1;
               held_addr = mem_addr_o;
               req_age   = 0;
            end else begin
               chk_val("addr_hold", 32'(mem_addr_o), 32'(held_addr));
            end
            if (req_age >= gnt_delay) begin
               mem_gnt_i = 1'b1;
               got_addr.push_back(mem_addr_o);
               rv_addr   = mem_addr_o;
               rv_pend   = 1'b1;
               rv_dly    = rd_lat;
               req_seen  = 1'b0;
            end else begin
               req_age++;
               if (spur_en) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = 15'h7FFF;
               end
            end
         end else if (req_seen) begin
            chk_val("req_hold", 32'(mem_req_o), 32'd1);
            req_seen = 1'b0;
         end
      end
   end

   // Result sink: optionally holds ready low for stall_len cycles of every word.
   initial begin
      int          stall_cnt = 0;
      logic [31:0] hw = '0;
      logic        hl = 1'b0;
      res_ready_i = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n || !res_valid_o) begin
            stall_cnt   = 0;
            res_ready_i = 1'b1;
         end else if (stall_cnt < stall_len) begin
            res_ready_i = 1'b0;
            if (stall_cnt == 0) begin
               hw = res_word_o;
               hl = res_last_o;
            end else begin
               chk_val("emit_word_hold", res_word_o, hw);
               chk_val("emit_last_hold", 32'(res_last_o), 32'(hl));
            end
            chk_val("emit_no_req", 32'(mem_req_o), 32'd0);
            stall_cnt++;
         end else begin
            res_ready_i = 1'b1;
            got_words.push_back(res_word_o);
            got_last.push_back(res_last_o);
         end
      end
   end

   task automatic run_sweep(input logic [9:0] base, input logic [10:0] cnt, input bit poke,
                            output int cycles);
      @(negedge clk);
      edge_base_i = base;
      edge_cnt_i  = cnt;
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      cycles  = 1;
      while (!done_o && cycles < 5000) begin
         @(negedge clk);
         cycles++;
         if (poke && cycles == 10) begin
            start_i     = 1'b1;
            edge_base_i = 10'h100;
            edge_cnt_i  = 11'd3;
         end else begin
            start_i = 1'b0;
         end
      end
      start_i = 1'b0;
      chk_val("done_seen", 32'(done_o), 32'd1);
      @(negedge clk);
      chk_val("done_pulse", 32'(done_o), 32'd0);
      $display("sweep base=0x%0h cnt=%0d cycles=%0d words=%0d blocked=%0d",
               base, cnt, cycles, got_words.size(), blocked_o);
   endtask

   task automatic check_five(input string tag, input int a0, input int w0);
      logic [9:0] exp_a[5];
      exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002};
      chk_val({tag, "_naddr"}, 32'(got_addr.size() - a0), 32'd5);
      for (int i = 0; i < 5; i++)
         chk_val({tag, "_addr"}, 32'(got_addr[a0 + i]), 32'(exp_a[i]));
      chk_val({tag, "_nwords"}, 32'(got_words.size() - w0), 32'd1);
      chk_val({tag, "_word"}, got_words[w0], 32'h0000_000D);
      chk_val({tag, "_last"}, 32'(got_last[w0]), 32'd1);
      chk_val({tag, "_blocked"}, 32'(blocked_o), 32'd3);
   endtask

   initial begin
      int cyc;
      int a0, w0;
      int exp5;
`ifdef PRM_CHK_PIPE_EN
      exp5 = 5 * 4 + 2;
`else
      exp5 = 5 * 3 + 2;
`endif
      rst_n       = 1'b0;
      start_i     = 1'b0;
      edge_base_i = '0;
      edge_cnt_i  = '0;
      repeat (3) @(negedge clk);
      chk_val("rst_busy", 32'(busy_o), 32'd0);
      chk_val("rst_done", 32'(done_o), 32'd0);
      chk_val("rst_req", 32'(mem_req_o), 32'd0);
      chk_val("rst_valid", 32'(res_valid_o), 32'd0);
      chk_val("rst_blocked", 32'(blocked_o), 32'd0);
      chk_val("rst_code", 32'(chk_code_o), 32'd0);
      rst_n = 1'b1;

      // empty sweep
      a0 = got_addr.size(); w0 = got_words.size();
      run_sweep(10'h155, 11'd0, 1'b0, cyc);
      chk_val("cnt0_latency", 32'(cyc), 32'd1);
      chk_val("cnt0_naddr", 32'(got_addr.size() - a0), 32'd0);
      chk_val("cnt0_nwords", 32'(got_words.size() - w0), 32'd0);
      chk_val("cnt0_blocked", 32'(blocked_o), 32'd0);

      // five edges wrapping the address space, masks 1,0,1,1,0
      mask_mem = '0;
      mask_mem[10'h3FE] = 1'b1;
      mask_mem[10'h000] = 1'b1;
      mask_mem[10'h001] = 1'b1;
      a0 = got_addr.size(); w0 = got_words.size();
      run_sweep(10'h3FE, 11'd5, 1'b0, cyc);
      chk_val("cnt5_latency", 32'(cyc), 32'(exp5));
      check_five("cnt5", a0, w0);

      // 33 edges all blocked, sink stalls 10 cycles per word, ignored start mid-sweep
      mask_mem = '0;
      for (int i = 0; i < 33; i++) mask_mem[i] = 1'b1;
      stall_len = 10;
      a0 = got_addr.size(); w0 = got_words.size();
      run_sweep(10'h000, 11'd33, 1'b1, cyc);
      stall_len = 0;
      chk_val("cnt33_naddr", 32'(got_addr.size() - a0), 32'd33);
      chk_val("cnt33_addr_first", 32'(got_addr[a0]), 32'h000);
      chk_val("cnt33_addr_last", 32'(got_addr[a0 + 32]), 32'h020);
      chk_val("cnt33_nwords", 32'(got_words.size() - w0), 32'd2);
      chk_val("cnt33_word0", got_words[w0], 32'hFFFF_FFFF);
      chk_val("cnt33_last0", 32'(got_last[w0]), 32'd0);
      chk_val("cnt33_word1", got_words[w0 + 1], 32'h0000_0001);
      chk_val("cnt33_last1", 32'(got_last[w0 + 1]), 32'd1);
      chk_val("cnt33_blocked", 32'(blocked_o), 32'd33);

      // slow memory: grant after 3 cycles, data 2 cycles after grant, stray rvalid in FETCH
      mask_mem = '0;
      mask_mem[10'h3FE] = 1'b1;
      mask_mem[10'h000] = 1'b1;
      mask_mem[10'h001] = 1'b1;
      gnt_delay = 3;
      rd_lat    = 2;
      spur_en   = 1'b1;
      a0 = got_addr.size(); w0 = got_words.size();
      run_sweep(10'h3FE, 11'd5, 1'b0, cyc);
      check_five("slow", a0, w0);
      gnt_delay = 0;
      rd_lat    = 1;
      spur_en   = 1'b0;

      // asynchronous reset in the middle of a sweep
      @(negedge clk);
      edge_base_i = 10'h000;
      edge_cnt_i  = 11'd33;
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      chk_val("abort_busy_before", 32'(busy_o), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk_val("abort_busy", 32'(busy_o), 32'd0);
      chk_val("abort_done", 32'(done_o), 32'd0);
      chk_val("abort_req", 32'(mem_req_o), 32'd0);
      chk_val("abort_addr", 32'(mem_addr_o), 32'd0);
      chk_val("abort_valid", 32'(res_valid_o), 32'd0);
      chk_val("abort_word", res_word_o, 32'd0);
      chk_val("abort_blocked", 32'(blocked_o), 32'd0);
      chk_val("abort_code", 32'(chk_code_o), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      a0 = got_addr.size(); w0 = got_words.size();
      run_sweep(10'h3FE, 11'd5, 1'b0, cyc);
      chk_val("post_rst_latency", 32'(cyc), 32'(exp5));
      check_five("post_rst", a0, w0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
